// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game obstacle path.
//   state_e : obstacle spawner FSM states
//   slot_t  : one on-screen cactus slot {valid, tall, x}
package dino_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned X_W      = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   typedef struct packed {
      logic           valid;
      logic           tall;
      logic [X_W-1:0] x;
   } slot_t;

endpackage

// File: rtl/obstacle_slot.sv
// One cactus slot: holds valid/tall/x and scrolls left on move.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   move, step   : scroll this frame by step pixels
//   load         : spawn at SPAWN_X with tall = load_tall (wins over move)
//   clear        : empty the slot (wins over everything)
//   slot_o       : registered slot record
//   expire_c     : combinational, slot leaves the screen on this move
module obstacle_slot
   import dino_pkg::*;
#(
   parameter int unsigned SPAWN_X = SCREEN_W
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       move,
   input  logic [2:0] step,
   input  logic       load,
   input  logic       load_tall,
   input  logic       clear,
   output slot_t      slot_o,
   output logic       expire_c
);

   slot_t slot_q, slot_d;

   // A slot with fewer pixels left than the step falls off the left edge.
   assign expire_c = move && slot_q.valid && (slot_q.x < X_W'(step));

   always_comb begin
      slot_d = slot_q;
      if (clear) begin
         slot_d = '0;
      end else if (load) begin
         slot_d.valid = 1'b1;
         slot_d.tall  = load_tall;
         slot_d.x     = X_W'(SPAWN_X);
      end else if (expire_c) begin
         slot_d = '0;
      end else if (move && slot_q.valid) begin
         slot_d.x = slot_q.x - X_W'(step);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Cactus spawner: gap counter, slot allocation and per-frame scrolling.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   frame_tick   : one pulse per video frame
//   run          : game running
//   speed        : pixels per frame (0 behaves as 1)
//   random1      : RNG value, sampled on spawn ticks (bit0 = tall, value scales gap)
//   obs_x        : slot i x-position at [i*X_W +: X_W]
//   obs_valid    : slot occupied
//   obs_tall     : slot holds a tall cactus
//   spawn_pulse  : one cycle, a slot was spawned
//   score_pulse  : one cycle, one or more slots left the screen
module obstacle_spawner
#(
   parameter int unsigned NUM_SLOTS = 3,
   parameter int unsigned X_W       = 10,
   parameter int unsigned SPAWN_X   = 640,
   parameter int unsigned GAP_W     = 12,
   parameter int unsigned MIN_GAP   = 200,
   parameter int unsigned GAP_SCALE = 8
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic                     run,
   input  logic [2:0]               speed,
   input  logic [4:0]               random1,
   output logic [NUM_SLOTS*X_W-1:0] obs_x,
   output logic [NUM_SLOTS-1:0]     obs_valid,
   output logic [NUM_SLOTS-1:0]     obs_tall,
   output logic                     spawn_pulse,
   output logic                     score_pulse
);

   import dino_pkg::state_e;
   import dino_pkg::slot_t;
   import dino_pkg::IDLE;
   import dino_pkg::RUN;
   import dino_pkg::HALT;

   state_e               state_q, state_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [GAP_W-1:0]     gap_dec_c, gap_reload_c;
   logic                 spawn_q, spawn_d;
   logic                 score_q, score_d;
   logic [2:0]           step_c;
   logic                 move_c, clear_c;
   logic [NUM_SLOTS-1:0] load_c, expire_c, free_c, alloc_c;
   slot_t                slot_c [NUM_SLOTS];

   assign step_c       = (speed == 3'd0) ? 3'd1 : speed;
   assign gap_dec_c    = (gap_q <= GAP_W'(step_c)) ? '0 : gap_q - GAP_W'(step_c);
   assign gap_reload_c = GAP_W'(MIN_GAP + GAP_SCALE * 32'(random1));

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      obstacle_slot #(.SPAWN_X(SPAWN_X)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .move      (move_c),
         .step      (step_c),
         .load      (load_c[i]),
         .load_tall (random1[0]),
         .clear     (clear_c),
         .slot_o    (slot_c[i]),
         .expire_c  (expire_c[i])
      );
      // A slot freed by this tick's move is already available for the spawn.
      assign free_c[i]             = !slot_c[i].valid || expire_c[i];
      assign obs_x[i*X_W +: X_W]   = X_W'(slot_c[i].x);
      assign obs_valid[i]          = slot_c[i].valid;
      assign obs_tall[i]           = slot_c[i].tall;
   end

   // Lowest-indexed free slot, one-hot.
   always_comb begin
      alloc_c = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_c[i]) alloc_c = NUM_SLOTS'(1) << i;
      end
   end

   // Next state, slot controls and pulses.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      spawn_d = 1'b0;
      score_d = 1'b0;
      move_c  = 1'b0;
      clear_c = 1'b0;
      load_c  = '0;
      case (state_q)
         IDLE: begin
            clear_c = 1'b1;
            if (run) begin
               state_d = RUN;
               gap_d   = GAP_W'(MIN_GAP);
            end
         end
         RUN: begin
            if (!run) begin
               state_d = HALT;
            end else if (frame_tick) begin
               move_c  = 1'b1;
               score_d = |expire_c;
               gap_d   = gap_dec_c;
               // With no free slot the gap stays at zero and retries next tick.
               if (gap_dec_c == '0 && |free_c) begin
                  load_c  = alloc_c;
                  gap_d   = gap_reload_c;
                  spawn_d = 1'b1;
               end
            end
         end
         HALT: begin
            if (run) begin
               clear_c = 1'b1;
               gap_d   = GAP_W'(MIN_GAP);
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gap_q   <= GAP_W'(MIN_GAP);
         spawn_q <= 1'b0;
         score_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         spawn_q <= spawn_d;
         score_q <= score_d;
      end
   end

   assign spawn_pulse = spawn_q;
   assign score_pulse = score_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with a per-cycle reference model.
module tb_obstacle_spawner;

   logic        clk = 1'b0;
   logic        reset, frame_tick, run;
   logic [2:0]  speed;
   logic [4:0]  random1;
   logic [29:0] obs_x;
   logic [2:0]  obs_valid, obs_tall;
   logic        spawn_pulse, score_pulse;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   obstacle_spawner dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .run         (run),
      .speed       (speed),
      .random1     (random1),
      .obs_x       (obs_x),
      .obs_valid   (obs_valid),
      .obs_tall    (obs_tall),
      .spawn_pulse (spawn_pulse),
      .score_pulse (score_pulse)
   );

   // Reference model: game mode 0=idle 1=running 2=halted, positions as plain ints.
   int m_x [3];
   bit m_v [3];
   bit m_t [3];
   int m_gap;
   int m_mode;
   bit m_spawn, m_score;

   task automatic m_clear();
      for (int i = 0; i < 3; i++) begin
         m_x[i] = 0; m_v[i] = 1'b0; m_t[i] = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      int s;
      int slot;
      m_spawn = 1'b0;
      m_score = 1'b0;
      if (reset) begin
         m_clear();
         m_gap  = 200;
         m_mode = 0;
      end else if (m_mode == 0) begin
         m_clear();
         if (run) begin m_mode = 1; m_gap = 200; end
      end else if (m_mode == 2) begin
         if (run) begin m_clear(); m_gap = 200; m_mode = 1; end
      end else if (!run) begin
         m_mode = 2;
      end else if (frame_tick) begin
         s = (speed == 0) ? 1 : int'(speed);
         for (int i = 0; i < 3; i++) begin
            if (m_v[i]) begin
               if (m_x[i] < s) begin
                  m_v[i] = 1'b0; m_x[i] = 0; m_t[i] = 1'b0; m_score = 1'b1;
               end else begin
                  m_x[i] = m_x[i] - s;
               end
            end
         end
         m_gap = (m_gap <= s) ? 0 : m_gap - s;
         slot = -1;
         for (int i = 2; i >= 0; i--) if (!m_v[i]) slot = i;
         if (m_gap == 0 && slot >= 0) begin
            m_v[slot] = 1'b1;
            m_x[slot] = 640;
            m_t[slot] = random1[0];
            m_gap     = 200 + 8 * int'(random1);
            m_spawn   = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [29:0] ex;
      logic [2:0]  ev, et;
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            ex[i*10 +: 10] = 10'(m_x[i]);
            ev[i] = m_v[i];
            et[i] = m_t[i];
         end
         checks++;
         if ({obs_x, obs_valid, obs_tall, spawn_pulse, score_pulse} !== {ex, ev, et, m_spawn, m_score}) begin
            errors++;
            $display("FAIL model t=%0t: got x=%h v=%b t=%b sp=%b sc=%b, want x=%h v=%b t=%b sp=%b sc=%b",
                     $time, obs_x, obs_valid, obs_tall, spawn_pulse, score_pulse,
                     ex, ev, et, m_spawn, m_score);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int xs(input int i);
      return int'(obs_x[i*10 +: 10]);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; frame_tick = 1'b0; speed = 3'd1; random1 = 5'd0;
      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_valid", int'(obs_valid), 0);
      chk("reset_x", int'(obs_x), 0);
      chk("reset_pulses", int'({spawn_pulse, score_pulse}), 0);

      // First spawn after 200 px at speed 1.
      reset = 1'b0; run = 1'b1; random1 = 5'd4;
      @(negedge clk);
      tick(199);
      chk("pre_spawn_valid", int'(obs_valid), 0);
      tick(1);
      chk("spawn0_valid", int'(obs_valid), 1);
      chk("spawn0_x", xs(0), 640);
      chk("spawn0_tall", int'(obs_tall), 0);
      chk("spawn0_pulse", int'(spawn_pulse), 1);
      chk("gap_reload_232", m_gap, 232);
      @(negedge clk);
      chk("spawn_pulse_1cyc", int'(spawn_pulse), 0);
      tick(1);
      chk("move_speed1", xs(0), 639);
      speed = 3'd0;
      tick(1);
      chk("move_speed0", xs(0), 638);
      speed = 3'd1;

      // Fill all three slots.
      random1 = 5'd1;
      tick(230);
      chk("spawn1_valid", int'(obs_valid), 3);
      chk("spawn1_x0", xs(0), 408);
      chk("spawn1_x1", xs(1), 640);
      chk("spawn1_tall", int'(obs_tall), 2);
      chk("gap_reload_208", m_gap, 208);
      random1 = 5'd0;
      tick(208);
      chk("spawn2_valid", int'(obs_valid), 7);
      chk("spawn2_x0", xs(0), 200);
      chk("spawn2_x1", xs(1), 432);
      chk("spawn2_x2", xs(2), 640);

      // Gap runs out with every slot busy: no spawn.
      tick(200);
      chk("full_valid", int'(obs_valid), 7);
      chk("full_x0", xs(0), 0);
      chk("full_no_spawn", int'(spawn_pulse), 0);
      chk("full_gap0", m_gap, 0);
      random1 = 5'd3;
      tick(1);
      chk("respawn_score", int'(score_pulse), 1);
      chk("respawn_spawn", int'(spawn_pulse), 1);
      chk("respawn_x0", xs(0), 640);
      chk("respawn_tall", int'(obs_tall), 3);
      chk("respawn_x1", xs(1), 231);
      chk("respawn_x2", xs(2), 439);

      // Speed 4: slot1 walks down to x=3 then expires.
      speed = 3'd4;
      tick(57);
      chk("s4_x1", xs(1), 3);
      chk("s4_x0", xs(0), 412);
      chk("s4_x2", xs(2), 211);
      chk("s4_gap_held", m_gap, 0);
      random1 = 5'd2;
      tick(1);
      chk("s4_score", int'(score_pulse), 1);
      chk("s4_spawn", int'(spawn_pulse), 1);
      chk("s4_x1_new", xs(1), 640);
      chk("s4_x0", xs(0), 408);
      chk("s4_x2", xs(2), 207);
      chk("s4_tall", int'(obs_tall), 1);
      @(negedge clk);
      chk("score_pulse_1cyc", int'(score_pulse), 0);

      // Halt freezes the screen, even with a coincident tick.
      speed = 3'd1; run = 1'b0;
      tick(11);
      chk("halt_valid", int'(obs_valid), 7);
      chk("halt_x0", xs(0), 408);
      chk("halt_x1", xs(1), 640);
      chk("halt_x2", xs(2), 207);
      chk("halt_tall", int'(obs_tall), 1);
      chk("halt_pulses", int'({spawn_pulse, score_pulse}), 0);
      run = 1'b1;
      @(negedge clk);
      chk("restart_valid", int'(obs_valid), 0);
      chk("restart_x", int'(obs_x), 0);
      tick(199);
      chk("restart_pre", int'(obs_valid), 0);
      tick(1);
      chk("restart_spawn", int'(spawn_pulse), 1);
      chk("restart_x0", xs(0), 640);

      // Reset in the middle of a running game.
      tick(216);
      chk("prereset_valid", int'(obs_valid), 3);
      chk("prereset_x0", xs(0), 424);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_valid", int'(obs_valid), 0);
      chk("midreset_x", int'(obs_x), 0);
      chk("midreset_pulses", int'({spawn_pulse, score_pulse}), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("postreset_gap", m_gap, 200);
      tick(200);
      chk("postreset_spawn", int'(spawn_pulse), 1);
      chk("postreset_valid", int'(obs_valid), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Downstream consumer of the 5-bit pseudo-random cactus value.
- Decides when a new cactus appears and whether it is short or tall.
- Keeps up to NUM_SLOTS cacti on screen, scrolling them left once per frame.
- Feeds per-slot x-position, valid and height to the renderer and collision logic; pulses a score event when a cactus leaves the screen.

Parameters:
NUM_SLOTS, 3, number of concurrent obstacle slots
X_W, 10, x-position width in pixels
SPAWN_X, 640, x loaded into a newly spawned slot (right screen edge)
GAP_W, 12, gap counter width
MIN_GAP, 200, minimum pixel gap between spawns
GAP_SCALE, 8, gap added per unit of random value

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
run  in  1  game running (low = dino dead / not started)
speed  in  3  pixels moved per frame; 0 treated as 1
random1  in  5  pseudo-random value from the cactus RNG
obs_x  out  NUM_SLOTS*X_W  slot i x-position at bits [i*X_W +: X_W]
obs_valid  out  NUM_SLOTS  slot occupied
obs_tall  out  NUM_SLOTS  1 = tall cactus, 0 = short
spawn_pulse  out  1  one-cycle pulse when a slot is spawned
score_pulse  out  1  one-cycle pulse when a slot expires off-screen

Behaviour:
- Single clock. Reset is synchronous and active-high; it has priority over all other inputs.
- Reset forces state IDLE, obs_x=0, obs_valid=0, obs_tall=0, spawn_pulse=0, score_pulse=0 and gap=MIN_GAP.
- All outputs are registered. Effects of a frame_tick appear the cycle after it.
- Nothing happens between ticks.
- States:
  - IDLE: slots held cleared. On run=1, go to RUN with gap=MIN_GAP.
  - RUN: all work is done on frame_tick only (order below). On run=0, go to HALT on that cycle, with no move applied even if a tick coincides.
  - HALT: positions, valid and tall bits are frozen, so the game-over frame stays displayed. On run=1, clear all slots, set gap=MIN_GAP, go to RUN.
- Per-frame_tick order in RUN:
  1. Move/expire. Let s = max(speed,1). For each valid slot: if x < s, clear valid and x; otherwise x -= s.
  2. Score. score_pulse=1 if any slot expired this tick. Multiple simultaneous expiries still give a single pulse.
  3. Gap. gap = (gap <= s) ? 0 : gap - s (saturating).
  4. Spawn. If gap==0 and a free slot exists, including a slot freed in step 1 of the same tick:
     - Fill the lowest-indexed free slot: x=SPAWN_X, tall=random1[0].
     - Reload gap = MIN_GAP + random1*GAP_SCALE, computed at GAP_W bits with no overflow at the defaults (max 448).
     - Pulse spawn_pulse.
     - A newly spawned slot is not moved on its spawn tick.
  5. No free slot: gap holds at 0 and the spawn retries on every subsequent tick.
- random1 is sampled only on a spawn tick. There is no handshake and the value is assumed stable at that cycle.
- spawn_pulse and score_pulse are high for exactly one cycle. They are 0 in IDLE and HALT.

Decomposition:
- Package dino_pkg:
  - state enum {IDLE, RUN, HALT}
  - constants SCREEN_W=640, X_W=10
  - typedef for a slot record {valid, tall, x}
- Sub-module obstacle_slot, one instance per slot. It holds valid/tall/x and takes move, step, load, load_tall and clear. It outputs the slot record and an expire pulse.
- Top level keeps the FSM, gap counter, free-slot priority encoder and pulse generation.

Test Plan:
- Reset during RUN with 2 slots valid -> next cycle obs_valid=0, obs_x=0, no pulses, state IDLE; run still 1 -> RUN on the following cycle, gap=200.
- run=1, speed=1, random1=5'd4 -> after 200 ticks slot0 valid, x=640, tall=0, spawn_pulse once; gap reloads 232; slot0 x=639 on the next tick.
- speed=0 -> identical to speed=1 (slot moves 1 px/tick).
- Slot0 at x=3, speed=4, tick -> slot0 invalid, x=0, score_pulse for one cycle; two slots expiring on the same tick -> one score_pulse.
- All 3 slots valid, gap reaches 0 -> no spawn, gap stays 0. Tick where slot1 expires -> slot1 respawned at 640 that same tick with tall=random1[0]; score_pulse and spawn_pulse both high.
- run drops in RUN with slots at x=500/300 -> 10 ticks leave them unchanged (HALT, no pulses). run re-asserted -> all slots cleared, first spawn after 200 px.
